// File: rtl/dat_read.sv
// SD DAT-line block receiver: start bit, data bytes, per-line CRC16-CCITT check, end bit.
// Defining SDHCI_DAT_READ_TIMEOUT_EN adds a start-bit timeout of TimeoutCycles enables.
module dat_read #(
  parameter int unsigned MaxBlockBitSize = 10,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sd_clk_en_p_i,
  input  logic [3:0]                 dat_i,
  input  logic                       start_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic                       bus_width_is_4_i,
  output logic [31:0]                data_o,
  output logic                       data_valid_o,
  output logic                       receiving_o,
  output logic                       done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       data_timeout_o
);
  localparam int unsigned CntW = MaxBlockBitSize + 4;

  typedef enum logic [2:0] {
    StReady, StWaitStart, StDat, StCrc, StEndBit, StDone
  } state_e;

  state_e                     state_q;
  logic [CntW-1:0]            cnt_q;
  logic [MaxBlockBitSize-1:0] size_q;
  logic                       bus4_q;
  logic [6:0]                 byte_q;
  logic [31:0]                word_q;
  logic [15:0]                crc_q [4];
  logic                       crc_err_q, end_err_q, timeout_q;

  logic [CntW-1:0] dat_len;
  logic [7:0]      byte_d;
  logic [31:0]     word_d;
  logic [1:0]      byte_idx;
  logic [3:0]      line_mask;
  logic            byte_done, last_dat, start_bit, timeout_hit;

  function automatic logic [15:0] crc16_step(logic [15:0] c, logic b);
    return {c[14:0], 1'b0} ^ ({16{c[15] ^ b}} & 16'h1021);
  endfunction

  always_comb begin
    dat_len   = bus4_q ? CntW'({size_q, 1'b0}) : CntW'({size_q, 3'b000});
    last_dat  = (cnt_q == dat_len - CntW'(1));
    byte_d    = bus4_q ? {byte_q[3:0], dat_i} : {byte_q, dat_i[0]};
    byte_done = bus4_q ? cnt_q[0] : (&cnt_q[2:0]);
    byte_idx  = bus4_q ? cnt_q[2:1] : cnt_q[4:3];
    word_d    = word_q;
    word_d[8*byte_idx +: 8] = byte_d;
    line_mask = bus4_q ? 4'hF : 4'h1;
    start_bit = bus4_q ? (dat_i == 4'h0) : ~dat_i[0];
  end

`ifdef SDHCI_DAT_READ_TIMEOUT_EN
  assign timeout_hit = (cnt_q == CntW'(TimeoutCycles - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_hit        = 1'b0;
`endif

  assign receiving_o = (state_q != StReady);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StReady;
      cnt_q          <= '0;
      size_q         <= '0;
      bus4_q         <= 1'b0;
      byte_q         <= '0;
      word_q         <= '0;
      crc_q          <= '{default: '0};
      crc_err_q      <= 1'b0;
      end_err_q      <= 1'b0;
      timeout_q      <= 1'b0;
      data_o         <= '0;
      data_valid_o   <= 1'b0;
      done_o         <= 1'b0;
      crc_err_o      <= 1'b0;
      end_bit_err_o  <= 1'b0;
      data_timeout_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      done_o       <= 1'b0;
      if (sd_clk_en_p_i) begin
        unique case (state_q)
          StReady: begin
            if (start_i) begin
              state_q        <= StWaitStart;
              cnt_q          <= '0;
              size_q         <= block_size_i;
              bus4_q         <= bus_width_is_4_i;
              byte_q         <= '0;
              word_q         <= '0;
              crc_q          <= '{default: '0};
              crc_err_q      <= 1'b0;
              end_err_q      <= 1'b0;
              timeout_q      <= 1'b0;
              crc_err_o      <= 1'b0;
              end_bit_err_o  <= 1'b0;
              data_timeout_o <= 1'b0;
            end
          end
          StWaitStart: begin
            if (start_bit) begin
              cnt_q   <= '0;
              state_q <= (size_q == '0) ? StCrc : StDat;
            end else if (timeout_hit) begin
              timeout_q <= 1'b1;
              state_q   <= StDone;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StDat: begin
            byte_q <= byte_d[6:0];
            for (int k = 0; k < 4; k++) crc_q[k] <= crc16_step(crc_q[k], dat_i[k]);
            // A word leaves on its 4th byte, or early on the block's last byte.
            if (byte_done) begin
              if (byte_idx == 2'd3 || last_dat) begin
                data_o       <= word_d;
                data_valid_o <= 1'b1;
                word_q       <= '0;
              end else begin
                word_q <= word_d;
              end
            end
            if (last_dat) begin
              cnt_q   <= '0;
              state_q <= StCrc;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StCrc: begin
            for (int k = 0; k < 4; k++) begin
              if (line_mask[k] && (dat_i[k] != crc_q[k][15])) crc_err_q <= 1'b1;
              crc_q[k] <= {crc_q[k][14:0], 1'b0};
            end
            if (cnt_q == CntW'(15)) begin
              cnt_q   <= '0;
              state_q <= StEndBit;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StEndBit: begin
            if (|(~dat_i & line_mask)) end_err_q <= 1'b1;
            state_q <= StDone;
          end
          StDone: begin
            done_o         <= 1'b1;
            crc_err_o      <= crc_err_q & ~timeout_q;
            end_bit_err_o  <= end_err_q & ~timeout_q;
            data_timeout_o <= timeout_q;
            state_q        <= StReady;
          end
          default: state_q <= StReady;
        endcase
      end
    end
  end

endmodule

// File: doc/dat_read.md
DAT_READ -- requirements
Module: dat_read

Interface
REQ-001 SHALL have parameter MaxBlockBitSize, default 10, meaning the width of block_size_i in bytes (maximum block size is 2^MaxBlockBitSize-1 bytes).
REQ-002 SHALL have parameter TimeoutCycles, default 1024, meaning the number of SD clock enables to wait for a start bit before timing out.
REQ-003 SHALL have port clk_i  input  1  system clock.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port sd_clk_en_p_i  input  1  SD clock rising-edge enable; all state advances and DAT sampling occur only on clk_i cycles where it is high.
REQ-006 SHALL have port dat_i  input  4  SD DAT[3:0] lines from the card.
REQ-007 SHALL have port start_i  input  1  begins a block read; honoured only in READY.
REQ-008 SHALL have port block_size_i  input  MaxBlockBitSize  block length in bytes; sampled when start_i is accepted.
REQ-009 SHALL have port bus_width_is_4_i  input  1  1 selects 4-bit mode, 0 selects 1-bit mode (DAT0 only); sampled when start_i is accepted.
REQ-010 SHALL have port data_o  output  32  received word; the first received byte of the word is in [7:0].
REQ-011 SHALL have port data_valid_o  output  1  one clk_i-cycle pulse when data_o holds a new word.
REQ-012 SHALL have port receiving_o  output  1  high in every state except READY.
REQ-013 SHALL have port done_o, crc_err_o, end_bit_err_o, data_timeout_o  output  1 each  completion pulse and status flags.

Function
REQ-014 SHALL implement the states READY, WAIT_START, DAT, CRC, END_BIT and DONE, with all transitions qualified by sd_clk_en_p_i.
REQ-015 SHALL transition READY->WAIT_START on start_i, clearing all error flags and counters.
REQ-016 SHALL leave WAIT_START when a start bit is seen (dat_i[0]==0 in 1-bit mode; dat_i==4'b0000 in 4-bit mode), going to DAT, or to CRC when block_size is 0.
REQ-017 SHALL remain in DAT for exactly 8*block_size cycles (1-bit mode) or 2*block_size cycles (4-bit mode), using a counter of MaxBlockBitSize+4 bits.
REQ-018 SHALL assemble each byte MSB-first: in 1-bit mode one bit per cycle from dat_i[0]; in 4-bit mode the high nibble first, then the low nibble.
REQ-019 SHALL place bytes little-endian into a 32-bit word and pulse data_valid_o for one clk_i cycle, on the sd_clk_en_p_i cycle in which the 4th byte completes.
REQ-020 SHALL emit a final partial word with unused upper bytes zero when block_size is not a multiple of 4, on the cycle its last byte completes.
REQ-021 SHALL run one CRC16-CCITT (x^16+x^12+x^5+1, initial value 0) per DAT line over the data bits only.
REQ-022 SHALL stay in CRC for 16 cycles, comparing the received bits MSB-first against each line's CRC; any mismatch sets crc_err; only line 0 is checked in 1-bit mode.
REQ-023 SHALL set end_bit_err in END_BIT if any checked line is 0, then go to DONE.
REQ-024 SHALL pulse done_o for one clk_i cycle in DONE (gated by sd_clk_en_p_i) and return to READY.
REQ-025 SHALL hold crc_err_o, end_bit_err_o and data_timeout_o registered from DONE until the next accepted start_i.
REQ-026 SHALL force crc_err_o and end_bit_err_o to 0 on a timeout.
REQ-027 SHALL ignore start_i outside READY.
REQ-028 SHALL hold all state when sd_clk_en_p_i is low.

Reset
REQ-029 SHALL, on rst_ni low at any time including mid-block, enter READY and clear the counters, CRCs and flags, with data_o=0 and data_valid_o, done_o, receiving_o, crc_err_o, end_bit_err_o and data_timeout_o all 0.

Configuration
REQ-030 SHALL, with SDHCI_DAT_READ_TIMEOUT_EN defined, count enables in WAIT_START; on reaching TimeoutCycles with no start bit, set data_timeout and go to DONE.
REQ-031 SHALL, without SDHCI_DAT_READ_TIMEOUT_EN, wait in WAIT_START indefinitely, with data_timeout_o tied to 0.

Verification
REQ-032 SHALL cover a 4-bit read of 512 bytes with incrementing pattern and correct CRC -> 128 data_valid_o pulses, first data_o=32'h03020100, done_o with no errors.
REQ-033 SHALL cover a 1-bit read of 6 bytes 0xA5..0xAA -> words 32'hA8A7A6A5 and 32'h0000AAA9, crc_err_o=0.
REQ-034 SHALL cover one flipped CRC bit on dat_i[2] in 4-bit mode -> crc_err_o=1, end_bit_err_o=0.
REQ-035 SHALL cover an end bit driven 0 -> end_bit_err_o=1 at done_o.
REQ-036 SHALL cover lines held high with the macro defined and TimeoutCycles=16 -> done_o after 16 enables, data_timeout_o=1, crc_err_o=0.
REQ-037 SHALL cover rst_ni asserted mid-DAT, then start_i -> receiving_o=0 during reset and a clean subsequent block is received.
